ap_mult_acc: RTL and testbench
==============================

// Module: ap_mult_acc
// PURPOSE
//  Downstream accumulator for the 12b approximate unsigned multiplier family. Takes the 24b product
//  stream (multiplier res) through a valid/ready handshake and sums products into a frame total.
//  Emits one frame total (dot product) with term count and overflow flag through its own handshake.
//  Sits between the combinational multiplier and the error-analysis / result-capture logic.
// PARAMETERS
//  PW  24  product width (multiplier res width)
//  AW  28  accumulator / sum width, AW >= PW
//  CW  8   term-counter width; max terms per frame = 2^CW-1
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   async active-low reset
//  prod_vld   in   1   product valid
//  prod_rdy   out  1   accumulator can accept a product
//  prod       in   PW  unsigned product
//  prod_last  in   1   qualifies prod as final term of the frame
//  sum_vld    out  1   frame total valid
//  sum_rdy    in   1   consumer accepts the total
//  sum        out  AW  frame total
//  sum_cnt    out  CW  number of terms in the frame
//  sum_ovf    out  1   accumulation exceeded 2^AW-1 in this frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ACC, acc=0, cnt=0, ovf_r=0; prod_rdy=1, sum_vld=0, sum=0, sum_cnt=0, sum_ovf=0.
//  - FSM has two states.
//    ACC: prod_rdy=1. Beat = prod_vld&prod_rdy.
//      Non-closing beat: acc<=acc+{0,prod}, cnt<=cnt+1, ovf_r|=carry-out.
//    ACC -> HOLD on a closing beat: a beat with prod_last=1, or a beat where cnt==2^CW-2 (forced close at 2^CW-1 terms).
//      On a closing beat, next edge: sum<=acc+prod, sum_cnt<=cnt+1, sum_ovf<=ovf_r|carry, sum_vld<=1.
//      Same edge also clears acc, cnt and ovf_r to 0.
//    HOLD: prod_rdy=0 and prod_vld is ignored. sum, sum_cnt and sum_ovf stay stable while sum_vld=1.
//    HOLD -> ACC on sum_vld&sum_rdy: sum_vld<=0 next edge. sum, sum_cnt and sum_ovf keep their last values.
//  - Latency: sum_vld rises exactly 1 cycle after the closing beat.
//  - Throughput: one bubble minimum per frame, because prod_rdy is low in the handshake cycle too.
//  - Arithmetic: unsigned; prod is zero-extended to AW.
//    Default: wraps mod 2^AW; ovf is sticky for the frame and set by any carry out of bit AW-1.
//  - prod_rdy is a pure decode of state (no combinational path from sum_rdy).
//  - sum_rdy is ignored while sum_vld=0.
//  - prod_last with a single beat: frame of 1 term, sum=prod, sum_cnt=1.
//  - Reset mid-frame or mid-HOLD discards the partial or pending total; no output is produced for it.
//  - Product of 0 is a valid term and is counted.
// CONFIGURATION
//  ACC_SAT_EN defined: on carry out, acc clamps to 2^AW-1 and stays there for the rest of the frame.
//    sum_ovf is still set. sum = 2^AW-1.
//  ACC_SAT_EN undefined: modular wrap as described above.
//  Port list, latency and handshake are identical in both builds.
// TESTING
//  T1 reset: assert rst_n=0 mid-cycle -> immediately prod_rdy=1, sum_vld=0, sum=0, sum_cnt=0, sum_ovf=0.
//  T2 basic: beats 100, 200, 300 (last on 3rd), sum_rdy=1
//     -> sum_vld=1 one cycle after beat 3, sum=600, sum_cnt=3, sum_ovf=0, single-cycle sum_vld.
//  T3 backpressure: frame {5} with sum_rdy=0 for 5 cycles, prod_vld held high with prod=9
//     -> sum=5 stable, prod_rdy=0 throughout.
//     After handshake, the next frame accepts 9; last -> sum=9, sum_cnt=1.
//  T4 overflow: 17 beats of 0xFFFFFF, last on 17th, sum_cnt=17, sum_ovf=1
//     -> sum=0x0FFFFEF; with ACC_SAT_EN, sum=0xFFFFFFF.
//     Then frame {1} -> sum_ovf=0.
//  T5 count limit: 256 beats of prod=1, no prod_last
//     -> first frame closes at beat 255: sum=255, sum_cnt=255.
//     Beat 256 (accepted after the HOLD handshake) opens a new frame.
//  T6 reset mid-frame: 2 beats of 50, then pulse rst_n low, then frame {7, last}
//     -> no sum_vld before reset; after reset, sum=7, sum_cnt=1.

Source files
------------

// File: rtl/ap_mult_acc.sv
// -----------------------------------------------------------------------------
// ap_mult_acc
// Frame accumulator for the 12b approximate unsigned multiplier family.
// Products arrive over a valid/ready handshake and are summed into a frame
// total. The total is then presented, with its term count and an overflow
// flag, over a second handshake.
//
// Build option:
//   ACC_SAT_EN  defined   -> the accumulator clamps at 2^AW-1 on the first
//                            carry-out and stays there until the frame closes.
//               undefined -> the accumulator wraps modulo 2^AW.
//   In both builds sum_ovf reports any carry-out within the frame.
//
// Ports:
//   clk        in   1    clock
//   rst_n      in   1    asynchronous active-low reset
//   prod_vld   in   1    product valid
//   prod_rdy   out  1    accumulator can accept a product (decoded from state)
//   prod       in   PW   unsigned product
//   prod_last  in   1    prod is the final term of the frame
//   sum_vld    out  1    frame total valid
//   sum_rdy    in   1    consumer accepts the frame total
//   sum        out  AW   frame total
//   sum_cnt    out  CW   number of terms in the frame
//   sum_ovf    out  1    the frame's accumulation exceeded 2^AW-1
// -----------------------------------------------------------------------------
module ap_mult_acc #(
   parameter int PW = 24,
   parameter int AW = 28,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          prod_vld,
   output logic          prod_rdy,
   input  logic [PW-1:0] prod,
   input  logic          prod_last,
   output logic          sum_vld,
   input  logic          sum_rdy,
   output logic [AW-1:0] sum,
   output logic [CW-1:0] sum_cnt,
   output logic          sum_ovf
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;

   // A frame is forced closed when the beat being accepted is term 2^CW-1.
   localparam logic [CW-1:0] CNT_CLOSE = {{(CW-1){1'b1}}, 1'b0};

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] sum_q, sum_d;
   logic [CW-1:0] sum_cnt_q, sum_cnt_d;
   logic          sum_ovf_q, sum_ovf_d;

   logic          beat;
   logic          closing;
   logic [AW:0]   add_full;
   logic          carry;
   logic [AW-1:0] add_res;

   // Both handshake outputs are pure state decodes: no path from sum_rdy.
   assign prod_rdy = (state_q == ACC);
   assign sum_vld  = (state_q == HOLD);
   assign sum      = sum_q;
   assign sum_cnt  = sum_cnt_q;
   assign sum_ovf  = sum_ovf_q;

   assign beat     = prod_vld & prod_rdy;
   assign closing  = prod_last | (cnt_q == CNT_CLOSE);

   // One extra bit captures the carry out of bit AW-1.
   assign add_full = {1'b0, acc_q} + (AW+1)'(prod);
   assign carry    = add_full[AW];

`ifdef ACC_SAT_EN
   // Once clamped, any further non-zero term carries again, so the
   // accumulator stays pinned at full scale for the rest of the frame.
   assign add_res  = carry ? {AW{1'b1}} : add_full[AW-1:0];
`else
   assign add_res  = add_full[AW-1:0];
`endif

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the
      // case leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      sum_d     = sum_q;
      sum_cnt_d = sum_cnt_q;
      sum_ovf_d = sum_ovf_q;

      case (state_q)
         ACC: begin
            if (beat) begin
               if (closing) begin
                  sum_d     = add_res;
                  sum_cnt_d = cnt_q + CW'(1);
                  sum_ovf_d = ovf_q | carry;
                  acc_d     = '0;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
                  state_d   = HOLD;
               end else begin
                  acc_d     = add_res;
                  cnt_d     = cnt_q + CW'(1);
                  ovf_d     = ovf_q | carry;
               end
            end
         end
         HOLD: begin
            // Products are ignored here; the total stays put until taken.
            if (sum_rdy) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         sum_cnt_q <= '0;
         sum_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         sum_q     <= sum_d;
         sum_cnt_q <= sum_cnt_d;
         sum_ovf_q <= sum_ovf_d;
      end
   end

endmodule

// File: tb/tb_ap_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_ap_mult_acc
// Self-checking bench for ap_mult_acc. A frame-level model (exact integer
// totals, then wrap or clamp) predicts every output, and a compare process
// checks the DUT against it on each falling edge. Directed scenarios add
// hand-computed literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_ap_mult_acc;

   localparam int    PW      = 24;
   localparam int    AW      = 28;
   localparam int    CW      = 8;
   localparam longint AW_MAX = (longint'(1) << AW) - 1;
   localparam int    MAX_TERMS = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prod_vld;
   logic          prod_rdy;
   logic [PW-1:0] prod;
   logic          prod_last;
   logic          sum_vld;
   logic          sum_rdy;
   logic [AW-1:0] sum;
   logic [CW-1:0] sum_cnt;
   logic          sum_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   ap_mult_acc #(.PW(PW), .AW(AW), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prod_vld  (prod_vld),
      .prod_rdy  (prod_rdy),
      .prod      (prod),
      .prod_last (prod_last),
      .sum_vld   (sum_vld),
      .sum_rdy   (sum_rdy),
      .sum       (sum),
      .sum_cnt   (sum_cnt),
      .sum_ovf   (sum_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Frame-level model: keep the exact running total, decide the reported
   // value only when the frame closes.
   // ---------------------------------------------------------------------------
   logic   m_hold;
   longint m_total;
   int     m_n;
   longint m_sum;
   int     m_cnt;
   logic   m_ovf;

   always @(posedge clk or negedge rst_n) begin
      longint t;
      int     n;
      logic   o;
      if (!rst_n) begin
         m_hold  <= 1'b0;
         m_total <= 0;
         m_n     <= 0;
         m_sum   <= 0;
         m_cnt   <= 0;
         m_ovf   <= 1'b0;
      end else if (!m_hold) begin
         if (prod_vld) begin
            t = m_total + longint'(prod);
            n = m_n + 1;
            if (prod_last || n == MAX_TERMS) begin
               o = (t > AW_MAX);
`ifdef ACC_SAT_EN
               m_sum <= o ? AW_MAX : t;
`else
               m_sum <= t % (AW_MAX + 1);
`endif
               m_cnt   <= n;
               m_ovf   <= o;
               m_hold  <= 1'b1;
               m_total <= 0;
               m_n     <= 0;
            end else begin
               m_total <= t;
               m_n     <= n;
            end
         end
      end else if (sum_rdy) begin
         m_hold <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("mdl prod_rdy", 64'(prod_rdy), 64'(!m_hold));
         check("mdl sum_vld",  64'(sum_vld),  64'(m_hold));
         check("mdl sum",      64'(sum),      64'(m_sum));
         check("mdl sum_cnt",  64'(sum_cnt),  64'(m_cnt));
         check("mdl sum_ovf",  64'(sum_ovf),  64'(m_ovf));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs change on the falling edge only.
   // ---------------------------------------------------------------------------
   task automatic send(input logic [PW-1:0] p, input logic last);
      int waited;
      prod_vld  = 1'b1;
      prod      = p;
      prod_last = last;
      waited    = 0;
      while (!prod_rdy && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!prod_rdy) check("send timeout", 64'(0), 64'(1));
      @(negedge clk);
      prod_vld  = 1'b0;
      prod_last = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic v, input longint s,
                            input int c, input logic o);
      check({tag, " sum_vld"}, 64'(sum_vld), 64'(v));
      check({tag, " sum"},     64'(sum),     64'(s));
      check({tag, " sum_cnt"}, 64'(sum_cnt), 64'(c));
      check({tag, " sum_ovf"}, 64'(sum_ovf), 64'(o));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      prod_vld  = 1'b0;
      prod      = '0;
      prod_last = 1'b0;
      sum_rdy   = 1'b1;

      // T1: reset values while rst_n is low.
      #1;
      check("T1 prod_rdy", 64'(prod_rdy), 64'(1));
      check_out("T1", 1'b0, 0, 0, 1'b0);
      #11 rst_n = 1'b1;
      @(negedge clk);

      // T2: 100 + 200 + 300, total visible the cycle after the last beat.
      send(24'd100, 1'b0);
      send(24'd200, 1'b0);
      send(24'd300, 1'b1);
      check_out("T2", 1'b1, 600, 3, 1'b0);
      @(negedge clk);
      check("T2 single sum_vld", 64'(sum_vld), 64'(0));

      // T3: backpressure holds {5}; a waiting 9 is refused until taken.
      send(24'd5, 1'b1);
      sum_rdy   = 1'b0;
      prod_vld  = 1'b1;
      prod      = 24'd9;
      prod_last = 1'b1;
      repeat (5) begin
         check("T3 prod_rdy", 64'(prod_rdy), 64'(0));
         check_out("T3", 1'b1, 5, 1, 1'b0);
         @(negedge clk);
      end
      sum_rdy = 1'b1;
      @(negedge clk);
      check("T3 reopen prod_rdy", 64'(prod_rdy), 64'(1));
      check("T3 reopen sum_vld",  64'(sum_vld),  64'(0));
      @(negedge clk);
      prod_vld  = 1'b0;
      prod_last = 1'b0;
      check_out("T3b", 1'b1, 9, 1, 1'b0);

      // T4: 17 x 0xFFFFFF = 0x10FFFFEF overflows 28 bits.
      for (int i = 0; i < 17; i++) send(24'hFF_FFFF, (i == 16));
`ifdef ACC_SAT_EN
      check_out("T4", 1'b1, 64'h0FFF_FFFF, 17, 1'b1);
`else
      check_out("T4", 1'b1, 64'h00FF_FFEF, 17, 1'b1);
`endif
      send(24'd1, 1'b1);
      check_out("T4b", 1'b1, 1, 1, 1'b0);

      // T5: no prod_last; frame forced closed at 255 terms.
      for (int i = 0; i < 255; i++) send(24'd1, 1'b0);
      check_out("T5", 1'b1, 255, 255, 1'b0);
      send(24'd1, 1'b0);
      send(24'd1, 1'b1);
      check_out("T5b", 1'b1, 2, 2, 1'b0);

      // T6: partial frame discarded by an asynchronous reset pulse.
      send(24'd50, 1'b0);
      send(24'd50, 1'b0);
      check("T6 no sum_vld", 64'(sum_vld), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      check("T6 prod_rdy", 64'(prod_rdy), 64'(1));
      check_out("T6 rst", 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send(24'd7, 1'b1);
      check_out("T6", 1'b1, 7, 1, 1'b0);
      @(negedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
